// File: rtl/rr_mux.sv
// rr_mux: registered N:1 multiplexer with valid/ready handshake and a 16-bit beat counter.
// Define RR_MUX_ROUNDROBIN_EN for round-robin arbitration; otherwise fixed priority (lowest index).
module rr_mux #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_sel,
    output logic [15:0]               beat_cnt
);

    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic [SELW-1:0]     r_out_sel;
    logic [15:0]         r_beat_cnt;

    logic                w_load_ok;
    logic                w_found;
    logic                w_in_xfer;
    logic                w_out_xfer;
    logic [SELW-1:0]     w_gidx;
    logic [CHANNELS-1:0] w_grant;
    logic [WIDTH-1:0]    w_sel_data;

`ifdef RR_MUX_ROUNDROBIN_EN
    logic [SELW-1:0]       r_ptr;
    logic [2*CHANNELS-1:0] w_dbl;
    logic [CHANNELS-1:0]   w_rot;
    logic [SELW:0]         w_sum;

    // Rotate the request vector so that bit k is channel (ptr + k) mod CHANNELS.
    always_comb begin
        w_dbl   = {in_valid, in_valid} >> r_ptr;
        w_rot   = w_dbl[CHANNELS-1:0];
        w_found = 1'b0;
        w_gidx  = '0;
        w_sum   = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + (SELW+1)'(k);
                if (w_sum >= (SELW+1)'(CHANNELS)) begin
                    w_sum = w_sum - (SELW+1)'(CHANNELS);
                end
                w_gidx  = w_sum[SELW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_in_xfer) begin
            r_ptr <= (w_gidx == SELW'(CHANNELS - 1)) ? '0 : w_gidx + 1'b1;
        end
    end
`else
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (!w_found && in_valid[k]) begin
                w_found = 1'b1;
                w_gidx  = SELW'(k);
            end
        end
    end
`endif

    assign w_grant    = w_found ? (CHANNELS'(1) << w_gidx) : '0;
    assign w_load_ok  = !r_out_valid || out_ready;
    assign in_ready   = w_grant & {CHANNELS{w_load_ok && !rst}};
    assign w_in_xfer  = |in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    always_comb begin
        w_sel_data = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (w_grant[i]) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A new load takes priority over draining, keeping one word per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_beat_cnt  <= '0;
        end else begin
            if (w_in_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_sel   <= w_gidx;
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
            end
            if (w_out_xfer) begin
                r_beat_cnt <= r_beat_cnt + 16'd1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign beat_cnt  = r_beat_cnt;

endmodule
